instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 26 ++
 rtl/instr_sequencer.sv | 85 ++++++++
 tb/tb_instr_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: word widths, opcode map and FSM states.
package instr_sequencer_pkg;

  localparam int IW  = 9;
  localparam int PCW = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_REP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IMM  = 2'd1,
    EXEC = 2'd2,
    ILL  = 2'd3
  } state_t;

  // Any opcode outside the defined set is rejected rather than executed.
  function automatic logic is_illegal(input logic [2:0] op);
    return !(op inside {OP_ADD, OP_SUB, OP_NAND, OP_OUT, OP_LDI, OP_REP});
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/decode sequencer: accepts instruction words, optionally an LDI immediate,
// then runs a four-step execute phase that drives the control unit step counter.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           run,
  input  logic           in_valid,
  input  logic [IW-1:0]  in_data,
  output logic           in_ready,
  output logic [IW-1:0]  ir,
  output logic [1:0]     count,
  output logic [IW-1:0]  imm,
  output logic           exec,
  output logic           done,
  output logic           illegal,
  output logic [PCW-1:0] pc
);

  state_t state, state_next;
  logic   xfer;

  assign xfer = in_valid && in_ready;

  // resetn is active-high and synchronous on this block.
  always_ff @(posedge clock) begin
    if (resetn) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (in_data[8:6] == OP_LDI)         state_next = IMM;
          else if (is_illegal(in_data[8:6])) state_next = ILL;
          else                               state_next = EXEC;
        end
      end
      IMM:  if (xfer) state_next = EXEC;
      EXEC: if (count == 2'b11) state_next = IDLE;
      ILL:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    exec     = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    unique case (state)
      IDLE: in_ready = run;
      IMM:  in_ready = 1'b1;
      EXEC: begin
        exec = 1'b1;
        done = (count == 2'b11);
      end
      ILL:  illegal = 1'b1;
      default: ;
    endcase
  end

  // The immediate word goes to imm; every other accepted word is an instruction.
  always_ff @(posedge clock) begin
    if (resetn) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      ir    <= '0;
      imm   <= '0;
      pc    <= '0;
      count <= 2'b00;
    end else begin
      if (xfer) begin
        pc <= pc + PCW'(1);
        if (state == IMM) imm <= in_data;
        else              ir  <= in_data;
      end
      count <= (state == EXEC) ? count + 2'd1 : 2'b00;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random traffic
// compared each cycle against a transaction-level reference model.
module tb_instr_sequencer;

  logic       clock;
  logic       resetn;
  logic       run;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_ready;
  logic [8:0] ir;
  logic [1:0] count;
  logic [8:0] imm;
  logic       exec;
  logic       done;
  logic       illegal;
  logic [7:0] pc;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen, exec_seen, ill_seen;

  // Reference model: an instruction is "busy" for a number of remaining execute
  // cycles; an LDI waits for its data word; a rejected word costs one flag cycle.
  int       m_exec_left;
  bit       m_await_imm;
  bit       m_ill;
  bit [8:0] m_ir, m_imm;
  int       m_pc;

  instr_sequencer dut (
    .clock    (clock),
    .resetn   (resetn),
    .run      (run),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ir       (ir),
    .count    (count),
    .imm      (imm),
    .exec     (exec),
    .done     (done),
    .illegal  (illegal),
    .pc       (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    if (m_await_imm) return 1'b1;
    if (m_exec_left > 0 || m_ill) return 1'b0;
    return run;
  endfunction

  function automatic int exp_count();
    return (m_exec_left > 0) ? 4 - m_exec_left : 0;
  endfunction

  task automatic model_reset();
    m_exec_left = 0;
    m_await_imm = 1'b0;
    m_ill       = 1'b0;
    m_ir        = '0;
    m_imm       = '0;
    m_pc        = 0;
  endtask

  task automatic model_edge(input bit xfer, input bit [8:0] data, input bit rst);
    int op;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_await_imm) begin
      if (xfer) begin
        m_imm       = data;
        m_pc        = (m_pc + 1) % 256;
        m_await_imm = 1'b0;
        m_exec_left = 4;
      end
    end else if (m_exec_left > 0) begin
      m_exec_left--;
    end else if (m_ill) begin
      m_ill = 1'b0;
    end else if (xfer) begin
      m_ir = data;
      m_pc = (m_pc + 1) % 256;
      op   = int'(data[8:6]);
      if (op == 5)               m_await_imm = 1'b1;
      else if (op == 3 || op == 6) m_ill     = 1'b1;
      else                       m_exec_left = 4;
    end
  endtask

  task automatic check_outputs();
    check("in_ready", 32'(in_ready), 32'(exp_ready()));
    check("ir",       32'(ir),       32'(m_ir));
    check("imm",      32'(imm),      32'(m_imm));
    check("pc",       32'(pc),       32'(m_pc));
    check("count",    32'(count),    32'(exp_count()));
    check("exec",     32'(exec),     32'(m_exec_left > 0));
    check("done",     32'(done),     32'(m_exec_left == 1));
    check("illegal",  32'(illegal),  32'(m_ill));
  endtask

  // Inputs are stable when called; compare, clock once, advance the model.
  task automatic tick();
    bit xfer;
    #1;
    check_outputs();
    xfer = in_valid && exp_ready();
    @(posedge clock);
    model_edge(xfer, in_data, resetn);
    #1;
    if (done)    done_seen++;
    if (exec)    exec_seen++;
    if (illegal) ill_seen++;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
  endtask

  initial begin
    resetn   = 1'b1;
    run      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clock);
    model_reset();
    #1;
    tick();
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    resetn = 1'b0;

    // ADD: four execute steps, done on the last, ready again afterwards.
    run = 1'b1; in_valid = 1'b1; in_data = 9'b000_001_010;
    tick();
    in_valid = 1'b0;
    check("add_ir", 32'(ir), 32'h00A);
    check("add_pc", 32'(pc), 32'd1);
    check("add_cnt0", 32'(count), 32'd0);
    tick(); tick(); tick();
    check("add_done", 32'(done), 32'd1);
    check("add_cnt3", 32'(count), 32'd3);
    tick();
    check("add_ready", 32'(in_ready), 32'd1);

    // LDI with a two-cycle gap before the immediate.
    do_reset();
    in_valid = 1'b1; in_data = 9'b101_011_000;
    tick();
    in_valid = 1'b0; in_data = 9'h0FF;
    tick(); tick();
    check("ldi_hold", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 9'h1A5;
    tick();
    in_valid = 1'b0;
    check("ldi_imm", 32'(imm), 32'h1A5);
    check("ldi_pc", 32'(pc), 32'd2);
    check("ldi_exec", 32'(exec), 32'd1);
    repeat (4) tick();

    // Illegal opcode: single flag cycle, no execute.
    do_reset();
    exec_seen = 0; ill_seen = 0;
    in_valid = 1'b1; in_data = 9'b011_000_000;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("ill_pulses", 32'(ill_seen), 32'd1);
    check("ill_no_exec", 32'(exec_seen), 32'd0);
    check("ill_pc", 32'(pc), 32'd1);

    // Run dropped mid-execute: completes, then holds.
    do_reset();
    done_seen = 0;
    in_valid = 1'b1; in_data = 9'b001_010_011;
    tick();
    tick();
    check("drop_cnt1", 32'(count), 32'd1);
    run = 1'b0;
    repeat (5) tick();
    check("drop_done", 32'(done_seen), 32'd1);
    check("drop_notready", 32'(in_ready), 32'd0);
    run = 1'b1;
    tick();

    // Reset during execute at count=10: abandoned, no done.
    do_reset();
    done_seen = 0;
    in_valid = 1'b1; in_data = 9'b010_111_001;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("rexec_cnt2", 32'(count), 32'd2);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    check("rexec_cnt", 32'(count), 32'd0);
    check("rexec_pc", 32'(pc), 32'd0);
    check("rexec_ir", 32'(ir), 32'd0);
    repeat (3) tick();
    check("rexec_nodone", 32'(done_seen), 32'd0);

    // Reset wins over a simultaneous transfer.
    resetn = 1'b1; in_valid = 1'b1; in_data = 9'b100_000_001;
    tick();
    resetn = 1'b0; in_valid = 1'b0;
    check("rprio_pc", 32'(pc), 32'd0);

    // Wrap: 256 back-to-back SUB words.
    do_reset();
    done_seen = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 256 * 5; i++) begin
      in_data = {3'b001, 6'($urandom)};
      tick();
    end
    in_valid = 1'b0;
    check("wrap_done", 32'(done_seen), 32'd256);
    check("wrap_pc", 32'(pc), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      run      = ($urandom_range(0, 7) != 0);
      in_valid = $urandom_range(0, 1);
      in_data  = 9'($urandom);
      resetn   = ($urandom_range(0, 63) == 0);
      tick();
    end
    resetn = 1'b0;
    in_valid = 1'b0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
